icache_responder: RTL and testbench

- Direct-mapped, read-only instruction cache that answers the pipeline's instruction-fetch requests on the datapath/cache interface.
- Inputs from the datapath: imemREN, imemaddr. Outputs to the datapath: ihit, imemload.
- Misses are filled one word at a time from the RAM/arbiter side through a blocking iREN/iwait handshake.
- Sits between the datapath fetch port and the memory arbiter.

---
 rtl/icache_responder_if.sv | 30 +++
 rtl/icache_responder.sv | 150 +++++++++++++++
 tb/tb_icache_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder_if
//  Description : Fetch-port and fill-port signal bundle for icache_responder.
//                slave  = the cache itself.
//                master = its environment (datapath fetch stage plus the
//                         RAM/arbiter that answers fills).
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    modport slave (
        input  imemREN, imemaddr, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );
endinterface
`default_nettype wire

// File: rtl/icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icache_responder
//  Description : Direct-mapped, read-only, one-word-per-frame instruction
//                cache. Hits answer combinationally in IDLE; misses are
//                filled one word at a time through a blocking iREN/iwait
//                handshake, then the lookup is replayed in IDLE.
//                Optional macro ICACHE_STATS_EN adds saturating hit/miss
//                counters as extra outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic              CLK,
    input  logic              RST,
    icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic              iren_q, iren_d;
    logic [SETS-1:0]   valid_q, valid_d;

    // Tag/data storage carries no reset: valid_q alone qualifies every entry.
    logic [TAG_W-1:0]  tag_mem_q  [SETS];
    logic [31:0]       data_mem_q [SETS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              lookup_hit;
    logic              fill_en;
    logic              unused_addr_bits;

    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign req_tag  = bus.imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    // Byte offset within the word never takes part in lookup or fill.
    assign unused_addr_bits = ^bus.imemaddr[1:0];

    // Lookup only happens in IDLE, so a fill can never race a read.
    always_comb begin
        lookup_hit   = (state_q == IDLE) && bus.imemREN && valid_q[req_idx]
                       && (tag_mem_q[req_idx] == req_tag);
        bus.ihit     = lookup_hit;
        bus.imemload = lookup_hit ? data_mem_q[req_idx] : 32'h0;
        bus.iREN     = iren_q;
        bus.iaddr    = iren_q ? miss_addr_q : 32'h0;
        fill_en      = (state_q == FETCH) && !bus.iwait && !RST;
    end

    // Next-state: a miss latches its word address; the fill retires on the
    // first FETCH cycle with iwait low, regardless of what imemaddr does.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.imemREN && !lookup_hit) begin
                    miss_addr_d = {bus.imemaddr[31:2], 2'b00};
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (!bus.iwait) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        iren_d = (state_d == FETCH);
    end

    // Control state and the registered fill request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0;
            iren_q      <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            iren_q      <= iren_d;
            valid_q     <= valid_d;
        end
    end

    // Fill write: the frame is overwritten unconditionally (no dirty state).
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_mem_q[fill_idx]  <= fill_tag;
            data_mem_q[fill_idx] <= bus.iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Saturating event counters: hits per IDLE hit cycle, misses per
    // IDLE->FETCH transition.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (lookup_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == IDLE) && (state_d == FETCH)
            && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_responder
//  Description : Self-checking bench for icache_responder (SETS=16):
//                directed cycle table followed by randomized traffic
//                compared against a word-addressed cache model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_responder_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_responder #(.SETS(16)) dut (
        .CLK        (clk),
        .RST        (rst),
        .bus        (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model (word-addressed lines) ----------------
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [31:0] m_pend;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic bit model_hit();
        int idx = int'(bus.imemaddr[5:2]);
        return !m_busy && bus.imemREN && m_valid[idx]
               && (m_word[idx] == bus.imemaddr[31:2]);
    endfunction

    function automatic void model_update();
        int idx;
        if (rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy   = 1'b0;
            m_pend   = 32'h0;
            m_hits   = 32'h0;
            m_misses = 32'h0;
        end else if (!m_busy) begin
            if (model_hit()) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
            end else if (bus.imemREN) begin
                m_busy = 1'b1;
                m_pend = {bus.imemaddr[31:2], 2'b00};
                if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
            end
        end else if (!bus.iwait) begin
            idx          = int'(m_pend[5:2]);
            m_valid[idx] = 1'b1;
            m_word[idx]  = m_pend[31:2];
            m_data[idx]  = bus.iload;
            m_busy       = 1'b0;
        end
    endfunction

    task automatic check(input string name, input int n,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit ren, input logic [31:0] a,
                         input bit w, input logic [31:0] ld);
        rst          = r;
        bus.imemREN  = ren;
        bus.imemaddr = a;
        bus.iwait    = w;
        bus.iload    = ld;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rst;
        bit          ren;
        logic [31:0] addr;
        bit          iwait;
        logic [31:0] iload;
        bit          chk;
        bit          e_hit;
        logic [31:0] e_load;
        bit          e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit ren, logic [31:0] a, bit w,
                                logic [31:0] ld, bit c, bit eh,
                                logic [31:0] el, bit er, logic [31:0] ea);
        vec_t v;
        v = '{r, ren, a, w, ld, c, eh, el, er, ea};
        tbl.push_back(v);
    endfunction

    localparam logic [31:0] D0 = 32'h2001_0004;
    localparam logic [31:0] D1 = 32'hA5A5_0040;
    localparam logic [31:0] D2 = 32'h1111_0010;
    localparam logic [31:0] D3 = 32'h2222_0020;
    localparam logic [31:0] D4 = 32'h4444_0008;

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);

        //   rst ren addr      wait iload  chk hit load  iren iaddr
        add(1, 0, 32'h00, 1, 32'h0, 0, 0, 32'h0, 0, 32'h00);
        add(0, 0, 32'h00, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00); // reset state
        // cold miss, 3 wait cycles then data
        add(0, 1, 32'h00, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 0, 32'h0, 1, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 0, 32'h0, 1, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 0, 32'h0, 1, 32'h00);
        add(0, 1, 32'h00, 0, D0,    1, 0, 32'h0, 1, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 1, D0,    0, 32'h00);
        // hit path, byte offset ignored, no RAM traffic
        for (int i = 0; i < 5; i++)
            add(0, 1, 32'h02, 1, 32'h0, 1, 1, D0, 0, 32'h00);
        // conflict on index 0, zero-wait fills
        add(0, 1, 32'h40, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h40, 0, D1,    1, 0, 32'h0, 1, 32'h40);
        add(0, 1, 32'h40, 1, 32'h0, 1, 1, D1,    0, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h00, 0, D0,    1, 0, 32'h0, 1, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 1, D0,    0, 32'h00);
        // address change mid-fill
        add(0, 1, 32'h10, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h20, 1, 32'h0, 1, 0, 32'h0, 1, 32'h10);
        add(0, 0, 32'h20, 1, 32'h0, 1, 0, 32'h0, 1, 32'h10);
        add(0, 1, 32'h20, 0, D2,    1, 0, 32'h0, 1, 32'h10);
        add(0, 1, 32'h20, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h20, 0, D3,    1, 0, 32'h0, 1, 32'h20);
        add(0, 1, 32'h10, 1, 32'h0, 1, 1, D2,    0, 32'h00);
        add(0, 1, 32'h20, 1, 32'h0, 1, 1, D3,    0, 32'h00);
        // reset mid-FETCH, RAM answer in the reset cycle is dropped
        add(0, 1, 32'h08, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h08, 1, 32'h0, 1, 0, 32'h0, 1, 32'h08);
        add(1, 1, 32'h08, 0, D4,    1, 0, 32'h0, 1, 32'h08);
        add(0, 0, 32'h08, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h08, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h08, 0, D4,    1, 0, 32'h0, 1, 32'h08);
        add(0, 1, 32'h00, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);
        add(0, 1, 32'h00, 0, D0,    1, 0, 32'h0, 1, 32'h00);
        add(0, 1, 32'h00, 1, 32'h0, 1, 1, D0,    0, 32'h00);
        add(0, 1, 32'h08, 1, 32'h0, 1, 1, D4,    0, 32'h00);
        add(0, 1, 32'h0B, 1, 32'h0, 1, 1, D4,    0, 32'h00);
        // no request: no hit even though the line is cached
        add(0, 0, 32'h00, 1, 32'h0, 1, 0, 32'h0, 0, 32'h00);

        @(posedge clk); #1;
        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].rst, tbl[n].ren, tbl[n].addr, tbl[n].iwait, tbl[n].iload);
            #3;
            if (tbl[n].chk) begin
                check("tbl_ihit",     n, {31'h0, bus.ihit}, {31'h0, tbl[n].e_hit});
                check("tbl_imemload", n, bus.imemload,      tbl[n].e_load);
                check("tbl_iREN",     n, {31'h0, bus.iREN}, {31'h0, tbl[n].e_iren});
                check("tbl_iaddr",    n, bus.iaddr,         tbl[n].e_iaddr);
            end
            model_update();
            @(posedge clk); #1;
        end

`ifdef ICACHE_STATS_EN
        // since the mid-FETCH reset: misses on 0x8 and 0x0, hits 0x0/0x8/0xB
        check("tbl_hit_count",  0, hit_count,  32'd3);
        check("tbl_miss_count", 0, miss_count, 32'd2);
`endif

        // ---------------- randomized traffic against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            bit          r;
            bit          eh;
            int          idx;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
            r = ($urandom_range(0, 199) == 0);
            drive(r, ($urandom_range(0, 3) != 0), a, ($urandom_range(0, 2) == 0),
                  $urandom());
            #3;
            eh  = model_hit();
            idx = int'(bus.imemaddr[5:2]);
            check("rnd_ihit",     n, {31'h0, bus.ihit}, {31'h0, eh});
            check("rnd_imemload", n, bus.imemload, eh ? m_data[idx] : 32'h0);
            check("rnd_iREN",     n, {31'h0, bus.iREN}, {31'h0, m_busy});
            check("rnd_iaddr",    n, bus.iaddr, m_busy ? m_pend : 32'h0);
`ifdef ICACHE_STATS_EN
            check("rnd_hit_count",  n, hit_count,  m_hits);
            check("rnd_miss_count", n, miss_count, m_misses);
`endif
            model_update();
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
